// File: rtl/interp_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// interp_ctrl_if : sample stream and coefficient config bus
// Rev 1.0
// ------------------------------------------------------------------
interface interp_ctrl_if #(
  parameter int DATA_WIDTH      = 5,
  parameter int TAP_COEFF_WIDTH = 5,
  parameter int NUM_TAPS        = 2
);
  localparam int c_addr_w = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_WIDTH-1:0]      in_data;
  logic                       cfg_wr;
  logic [c_addr_w-1:0]        cfg_addr;
  logic [TAP_COEFF_WIDTH-1:0] cfg_data;
  logic                       cfg_commit;

  modport master (
    output in_valid, in_data, cfg_wr, cfg_addr, cfg_data, cfg_commit,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, cfg_wr, cfg_addr, cfg_data, cfg_commit,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/interp_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// interp_ctrl : zero-stuffing sequencer and coefficient bank owner
// Rev 1.0
// ------------------------------------------------------------------
module interp_ctrl #(
  parameter int DATA_WIDTH      = 5,
  parameter int TAP_COEFF_WIDTH = 5,
  parameter int NUM_TAPS        = 2,
  parameter int MAX_FACTOR      = 8,
  parameter int FACTOR_WIDTH    = 4,
  parameter int FILT_LATENCY    = 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      enable_i,
  input  logic [FACTOR_WIDTH-1:0]                   factor_i,
  interp_ctrl_if.slave                              bus,
  output logic [DATA_WIDTH-1:0]                     filt_in_o,
  output logic                                      filt_out_valid_o,
  output logic                                      commit_pending_o,
  output logic [NUM_TAPS-1:0][TAP_COEFF_WIDTH-1:0]  tap_coeffs_o,
  output logic                                      busy_o,
  output logic                                      underrun_o
);

  localparam int c_phase_w = (MAX_FACTOR > 1) ? $clog2(MAX_FACTOR) : 1;
  localparam int c_drain_n = NUM_TAPS + FILT_LATENCY;
  localparam int c_drain_w = $clog2(c_drain_n + 1);
  localparam int c_vld_w   = (FILT_LATENCY > 1) ? FILT_LATENCY : 1;
  localparam logic [c_drain_w-1:0]    c_drain_init = c_drain_w'(c_drain_n - 1);
  localparam logic [FACTOR_WIDTH-1:0] c_max_factor = FACTOR_WIDTH'(MAX_FACTOR);
  localparam logic [FACTOR_WIDTH-1:0] c_one        = FACTOR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                                   state_q;
  logic [c_phase_w-1:0]                     phase_q;
  logic [c_phase_w-1:0]                     lm1_q;
  logic [c_drain_w-1:0]                     drain_q;
  logic [DATA_WIDTH-1:0]                    filt_in_q;
  logic                                     underrun_q;
  logic                                     commit_pending_q;
  logic [NUM_TAPS-1:0][TAP_COEFF_WIDTH-1:0] shadow_q;
  logic [NUM_TAPS-1:0][TAP_COEFF_WIDTH-1:0] active_q;
  logic [c_vld_w-1:0]                       vld_q;

  logic [FACTOR_WIDTH-1:0] w_leff;
  logic [c_phase_w-1:0]    w_lm1;
  logic                    w_run;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_stall;
  logic                    w_last;
  logic                    w_swap;
  logic                    w_addr_ok;

  // Factor is clamped to 1..MAX_FACTOR; the phase counter stores Leff-1 as its wrap point.
  assign w_leff = (factor_i <= c_one) ? c_one :
                  (factor_i > c_max_factor) ? c_max_factor : factor_i;
  assign w_lm1  = c_phase_w'(w_leff - c_one);

  assign w_run      = (state_q == S_RUN);
  assign w_in_ready = w_run && (phase_q == '0);
  assign w_accept   = w_in_ready && bus.in_valid;
  assign w_stall    = w_in_ready && !bus.in_valid;
  assign w_last     = (phase_q == lm1_q);
  assign w_swap     = commit_pending_q && ((state_q == S_IDLE) || w_accept);
  assign w_addr_ok  = (32'(bus.cfg_addr) < 32'(NUM_TAPS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      lm1_q      <= '0;
      drain_q    <= '0;
      filt_in_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          filt_in_q <= '0;
          phase_q   <= '0;
          if (enable_i) begin
            state_q    <= S_RUN;
            lm1_q      <= w_lm1;
            underrun_q <= 1'b0;
          end
        end
        S_RUN: begin
          filt_in_q <= w_accept ? bus.in_data : '0;
          if (w_stall) begin
            underrun_q <= 1'b1;
          end else begin
            phase_q <= w_last ? '0 : phase_q + c_phase_w'(1);
          end
          // A stall at phase 0 is also a period boundary, so enable is honoured there.
          if (!enable_i && (w_stall || w_last)) begin
            state_q <= S_DRAIN;
            drain_q <= c_drain_init;
          end
        end
        S_DRAIN: begin
          filt_in_q <= '0;
          if (drain_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            drain_q <= drain_q - c_drain_w'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A commit arriving in the swap cycle stays pending for the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q         <= '0;
      active_q         <= '0;
      commit_pending_q <= 1'b0;
    end else begin
      if (bus.cfg_wr && w_addr_ok) begin
        shadow_q[bus.cfg_addr] <= bus.cfg_data;
      end
      if (w_swap) begin
        active_q <= shadow_q;
      end
      if (bus.cfg_commit) begin
        commit_pending_q <= 1'b1;
      end else if (w_swap) begin
        commit_pending_q <= 1'b0;
      end
    end
  end

  generate
    if (FILT_LATENCY <= 1) begin : g_vld_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= w_run;
      end
    end else begin : g_vld_chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= {vld_q[c_vld_w-2:0], w_run};
      end
    end
  endgenerate

  assign bus.in_ready      = w_in_ready;
  assign filt_in_o         = filt_in_q;
  assign filt_out_valid_o  = vld_q[c_vld_w-1];
  assign commit_pending_o  = commit_pending_q;
  assign tap_coeffs_o      = active_q;
  assign busy_o            = (state_q != S_IDLE);
  assign underrun_o        = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_interp_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_interp_ctrl : directed self-checking bench for interp_ctrl
// Rev 1.0
// ------------------------------------------------------------------
module tb_interp_ctrl;
  localparam int DW = 5;
  localparam int CW = 5;
  localparam int NT = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   enable;
  logic [3:0]             factor;
  logic [DW-1:0]          filt_in;
  logic                   fov;
  logic                   pending;
  logic [NT-1:0][CW-1:0]  taps;
  logic                   busy;
  logic                   underrun;

  int vec  = 0;
  int errs = 0;

  interp_ctrl_if #(.DATA_WIDTH(DW), .TAP_COEFF_WIDTH(CW), .NUM_TAPS(NT)) bus ();

  interp_ctrl #(
    .DATA_WIDTH(DW), .TAP_COEFF_WIDTH(CW), .NUM_TAPS(NT),
    .MAX_FACTOR(8), .FACTOR_WIDTH(4), .FILT_LATENCY(2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable_i         (enable),
    .factor_i         (factor),
    .bus              (bus),
    .filt_in_o        (filt_in),
    .filt_out_valid_o (fov),
    .commit_pending_o (pending),
    .tap_coeffs_o     (taps),
    .busy_o           (busy),
    .underrun_o       (underrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle;
    int n = 0;
    enable = 1'b0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL go_idle busy: got %0b want 0 after %0d cycles", busy, n);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; factor = 4'd0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_commit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec++; if (filt_in !== '0)   begin errs++; $display("FAIL reset filt_in: got %0d want 0", filt_in); end
    vec++; if (fov !== 1'b0)     begin errs++; $display("FAIL reset fov: got %0b want 0", fov); end
    vec++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL reset in_ready: got %0b want 0", bus.in_ready); end
    vec++; if (busy !== 1'b0)    begin errs++; $display("FAIL reset busy: got %0b want 0", busy); end
    vec++; if (pending !== 1'b0) begin errs++; $display("FAIL reset pending: got %0b want 0", pending); end
    vec++; if (underrun !== 1'b0) begin errs++; $display("FAIL reset underrun: got %0b want 0", underrun); end
    vec++; if (taps !== '0)      begin errs++; $display("FAIL reset taps: got %h want 0", taps); end
    rst_n = 1'b1;
    tick();
    vec++; if (busy !== 1'b0)    begin errs++; $display("FAIL reset idle busy: got %0b want 0", busy); end
  endtask

  task automatic test_l4;
    int ef[10]  = '{0, 3, 0, 0, 0, -2, 0, 0, 0, 5};
    bit er[10]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    bit ev[10]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    int dat[10] = '{3, 9, 9, 9, -2, 9, 9, 9, 5, 9};
    factor = 4'd4; enable = 1'b1; bus.in_valid = 1'b1; bus.in_data = 5'(3);
    for (int k = 0; k < 10; k++) begin
      tick();
      vec++; if (filt_in !== 5'(ef[k])) begin errs++; $display("FAIL l4 filt_in c%0d: got %0d want %0d", k+1, $signed(filt_in), ef[k]); end
      vec++; if (bus.in_ready !== er[k]) begin errs++; $display("FAIL l4 in_ready c%0d: got %0b want %0b", k+1, bus.in_ready, er[k]); end
      vec++; if (fov !== ev[k])         begin errs++; $display("FAIL l4 fov c%0d: got %0b want %0b", k+1, fov, ev[k]); end
      vec++; if (busy !== 1'b1)         begin errs++; $display("FAIL l4 busy c%0d: got %0b want 1", k+1, busy); end
      bus.in_data = 5'(dat[k]);
    end
  endtask

  task automatic test_drain;
    bit eb[8] = '{1, 1, 1, 1, 1, 1, 0, 1};
    bit er[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    bit ev[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    enable = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      vec++; if (busy !== eb[k])        begin errs++; $display("FAIL drain busy c%0d: got %0b want %0b", k+11, busy, eb[k]); end
      vec++; if (bus.in_ready !== er[k]) begin errs++; $display("FAIL drain in_ready c%0d: got %0b want %0b", k+11, bus.in_ready, er[k]); end
      vec++; if (fov !== ev[k])         begin errs++; $display("FAIL drain fov c%0d: got %0b want %0b", k+11, fov, ev[k]); end
      vec++; if (filt_in !== '0)        begin errs++; $display("FAIL drain filt_in c%0d: got %0d want 0", k+11, $signed(filt_in)); end
      if (k == 3) enable = 1'b1;
    end
    go_idle();
  endtask

  task automatic test_factor_clamp;
    factor = 4'd0; enable = 1'b1; bus.in_valid = 1'b1; bus.in_data = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL l1 in_ready c%0d: got %0b want 1", k+1, bus.in_ready); end
      vec++; if (filt_in !== 5'(k))     begin errs++; $display("FAIL l1 filt_in c%0d: got %0d want %0d", k+1, filt_in, k); end
      bus.in_data = 5'(k + 1);
    end
    vec++; if (underrun !== 1'b0) begin errs++; $display("FAIL l1 underrun: got %0b want 0", underrun); end
    go_idle();
    factor = 4'd15; enable = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      vec++;
      if (bus.in_ready !== ((k % 8) == 0)) begin
        errs++; $display("FAIL l8 in_ready c%0d: got %0b want %0b", k+1, bus.in_ready, ((k % 8) == 0));
      end
    end
    go_idle();
  endtask

  task automatic test_underrun;
    bit er[7] = '{1, 1, 1, 0, 0, 1, 0};
    bit eu[7] = '{0, 1, 1, 1, 1, 1, 1};
    int ef[7] = '{0, 0, 0, 7, 0, 0, -5};
    bit sv[7] = '{0, 0, 1, 1, 1, 1, 1};
    int sd[7] = '{0, 0, 7, 9, 9, -5, 9};
    factor = 4'd3; enable = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0;
    for (int k = 0; k < 7; k++) begin
      tick();
      vec++; if (bus.in_ready !== er[k]) begin errs++; $display("FAIL urun in_ready c%0d: got %0b want %0b", k+1, bus.in_ready, er[k]); end
      vec++; if (underrun !== eu[k])    begin errs++; $display("FAIL urun underrun c%0d: got %0b want %0b", k+1, underrun, eu[k]); end
      vec++; if (filt_in !== 5'(ef[k])) begin errs++; $display("FAIL urun filt_in c%0d: got %0d want %0d", k+1, $signed(filt_in), ef[k]); end
      bus.in_valid = sv[k];
      bus.in_data  = 5'(sd[k]);
    end
    go_idle();
    vec++; if (underrun !== 1'b1) begin errs++; $display("FAIL urun sticky idle: got %0b want 1", underrun); end
    enable = 1'b1;
    tick();
    vec++; if (underrun !== 1'b0) begin errs++; $display("FAIL urun clear on run: got %0b want 0", underrun); end
    go_idle();
  endtask

  task automatic test_coeff;
    logic [NT-1:0][CW-1:0] t1;
    logic [NT-1:0][CW-1:0] t2;
    logic [NT-1:0][CW-1:0] et;
    bit ep[10] = '{0, 0, 1, 1, 1, 0, 1, 1, 1, 0};
    int ts[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2};
    int ef[10] = '{0, 6, 0, 0, 0, 6, 0, 0, 0, 6};
    t1 = {5'h1f, 5'h01};
    t2 = {5'h1f, 5'h05};
    factor = 4'd4; bus.in_valid = 1'b1; bus.in_data = 5'(6);
    bus.cfg_wr = 1'b1; bus.cfg_addr = 1'b0; bus.cfg_data = 5'h01;
    tick();
    bus.cfg_addr = 1'b1; bus.cfg_data = 5'h1f;
    tick();
    bus.cfg_wr = 1'b0;
    vec++; if (taps !== '0)      begin errs++; $display("FAIL coeff no-commit taps: got %h want 0", taps); end
    vec++; if (pending !== 1'b0) begin errs++; $display("FAIL coeff no-commit pending: got %0b want 0", pending); end
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      et = (ts[k] == 0) ? '0 : (ts[k] == 1) ? t1 : t2;
      vec++; if (pending !== ep[k])     begin errs++; $display("FAIL coeff pending c%0d: got %0b want %0b", k+1, pending, ep[k]); end
      vec++; if (taps !== et)           begin errs++; $display("FAIL coeff taps c%0d: got %h want %h", k+1, taps, et); end
      vec++; if (filt_in !== 5'(ef[k])) begin errs++; $display("FAIL coeff filt_in c%0d: got %0d want %0d", k+1, $signed(filt_in), ef[k]); end
      case (k)
        1: bus.cfg_commit = 1'b1;
        2: bus.cfg_commit = 1'b0;
        5: begin bus.cfg_commit = 1'b1; bus.cfg_wr = 1'b1; bus.cfg_addr = 1'b0; bus.cfg_data = 5'h05; end
        6: begin bus.cfg_commit = 1'b0; bus.cfg_wr = 1'b0; end
        8: begin bus.cfg_wr = 1'b1; bus.cfg_addr = 1'b1; bus.cfg_data = 5'h03; end
        9: bus.cfg_wr = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_async_reset;
    #2;
    rst_n = 1'b0;
    #1;
    vec++; if (filt_in !== '0)   begin errs++; $display("FAIL arst filt_in: got %0d want 0", $signed(filt_in)); end
    vec++; if (fov !== 1'b0)     begin errs++; $display("FAIL arst fov: got %0b want 0", fov); end
    vec++; if (taps !== '0)      begin errs++; $display("FAIL arst taps: got %h want 0", taps); end
    vec++; if (busy !== 1'b0)    begin errs++; $display("FAIL arst busy: got %0b want 0", busy); end
    vec++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL arst in_ready: got %0b want 0", bus.in_ready); end
    enable = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL arst idle busy: got %0b want 0", busy); end
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    tick();
    vec++; if (taps !== '0)      begin errs++; $display("FAIL arst shadow cleared: got %h want 0", taps); end
    vec++; if (pending !== 1'b0) begin errs++; $display("FAIL arst pending after swap: got %0b want 0", pending); end
  endtask

  initial begin
    test_reset();
    test_l4();
    test_drain();
    test_factor_clamp();
    test_underrun();
    test_coeff();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/interp_ctrl.md
Name: interp_ctrl

Overview:
Sequencing controller for the interpolation FIR datapath.
- Accepts input samples over a valid/ready handshake and zero-stuffs them by factor L into the filter's every-cycle sample input.
- Owns the filter's tap coefficient array, with a double-buffered write port and glitch-free bank swaps on sample boundaries.
- Generates a valid strobe aligned to the filter output.

Parameters:
DATA_WIDTH, 5, sample width (signed), matches filter
TAP_COEFF_WIDTH, 5, coefficient width (signed), matches filter
NUM_TAPS, 2, filter tap count
MAX_FACTOR, 8, largest supported interpolation factor L
FACTOR_WIDTH, 4, width of factor port
FILT_LATENCY, 2, filter input-to-output latency in cycles

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = in reset)
enable  input  1  run request; level-sensitive
factor  input  FACTOR_WIDTH  interpolation factor L, sampled only on IDLE->RUN
in_valid  input  1  upstream sample valid
in_ready  output  1  controller accepts in_data this cycle
in_data  input  DATA_WIDTH  signed upstream sample
filt_in  output  DATA_WIDTH  registered sample to filter input
filt_out_valid  output  1  filter output sample is meaningful this cycle
cfg_wr  input  1  write shadow coefficient
cfg_addr  input  $clog2(NUM_TAPS) (min 1)  shadow tap index
cfg_data  input  TAP_COEFF_WIDTH  shadow coefficient value
cfg_commit  input  1  request shadow->active swap
commit_pending  output  1  swap requested, not yet applied
tap_coeffs  output  TAP_COEFF_WIDTH x NUM_TAPS  active coefficient bank to filter
busy  output  1  state != IDLE
underrun  output  1  sticky: sample missing at phase 0 while in RUN

Behaviour:
- Reset (rst=0, async): state IDLE, phase=0, filt_in=0, filt_out_valid=0, in_ready=0, shadow and active banks all 0, commit_pending=0, underrun=0, valid pipeline cleared.
- Effective factor: Leff = 1 if factor<=1; MAX_FACTOR if factor>MAX_FACTOR; otherwise factor. Latched on the IDLE->RUN transition; factor changes during RUN are ignored.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - filt_in=0, in_ready=0.
  - enable=1 -> RUN with phase=0. Takes effect the next cycle; underrun is cleared on this transition.
- RUN:
  - Phase counter runs 0..Leff-1 and wraps to 0.
  - in_ready = (phase==0), combinational from state/phase.
  - Phase 0 with in_valid=1: next filt_in=in_data, phase advances.
  - Phase 0 with in_valid=0: next filt_in=0, underrun set, phase holds at 0 (retries next cycle).
  - Phase != 0: next filt_in=0.
  - Leff=1: in_ready is high every RUN cycle (pass-through).
- RUN->DRAIN: enable=0 is evaluated only at a period end, i.e. in the cycle where phase would wrap to 0. The partial period always completes. Dropping enable while stalled at phase 0 exits immediately.
- DRAIN:
  - Drives filt_in=0 for NUM_TAPS+FILT_LATENCY cycles (down-counter), then -> IDLE.
  - enable is ignored during DRAIN.
- filt_out_valid: delay line of FILT_LATENCY flops fed with (state==RUN). Reset clears it; DRAIN cycles feed 0.
- Coefficients:
  - cfg_wr writes shadow[cfg_addr]=cfg_data on the clock edge. Out-of-range cfg_addr is ignored.
  - cfg_commit sets commit_pending.
  - Swap (active<=shadow, commit_pending<=0) happens in any IDLE cycle, or in a RUN cycle accepting a sample (in_ready & in_valid). The new sample is the first one filtered with the new bank.
  - cfg_wr and cfg_commit in the same cycle: the write is included in the swap.
  - cfg_wr in the same cycle as a swap: the write goes to shadow only and is not in the active bank until the next commit.
  - tap_coeffs is registered. It never changes except on a swap.
- Arithmetic: no arithmetic on sample data. Counters wrap/terminate exactly as above, with no overflow possible given Leff<=MAX_FACTOR.

Test Plan:
- Reset release, L=4, enable=1, in_data 3,-2,5 always valid -> filt_in sequence 3,0,0,0,-2,0,0,0,5,...; in_ready high 1 cycle in 4; filt_out_valid rises exactly FILT_LATENCY cycles after the first RUN cycle.
- factor=0, then factor=15 with MAX_FACTOR=8 -> pass-through every cycle; then 1-in-8 in_ready spacing.
- L=3, in_valid low for 2 cycles at phase 0 -> filt_in 0,0 and phase held; underrun=1 until next IDLE->RUN; the next valid sample is accepted and stuffed normally.
- Write shadow {1,-1}, commit during RUN between samples -> tap_coeffs unchanged until the accept cycle, then {1,-1} one cycle later; commit_pending 1->0 at the same edge; same-cycle cfg_wr+commit includes the write.
- Drop enable at phase 1 of L=4 -> phases 2,3 still emitted, then NUM_TAPS+FILT_LATENCY=4 zero cycles, busy falls; enable re-asserted during DRAIN is ignored until IDLE.
- Assert rst=0 mid-RUN asynchronously -> all outputs 0 immediately (no clock edge needed), coefficient banks cleared, state IDLE after release.
